// File: rtl/ahb_slv_pkg.sv
// Shared encodings, FSM state codes and address-window defaults for the AHB side of the AHB-to-APB bridge.
package ahb_slv_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WDATA = 3'd1;
    localparam state_t ST_REQ   = 3'd2;
    localparam state_t ST_ERR1  = 3'd3;
    localparam state_t ST_ERR2  = 3'd4;

    localparam logic [31:0] REGION_BASE_DEF = 32'h8000_0000;
    localparam int          REGION_LOG2_DEF = 26;

    // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY get a zero-wait OKAY.
    function automatic logic is_active_trans(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational address decoder: maps haddr onto one of NSEL equally sized peripheral slots above REGION_BASE.
module ahb_addr_decode
    import ahb_slv_pkg::*;
#(
    parameter logic [31:0] REGION_BASE = REGION_BASE_DEF,
    parameter int          REGION_LOG2 = REGION_LOG2_DEF,
    parameter int          NSEL        = 3
) (
    input  logic [31:0]     i_haddr,
    output logic            o_hit,
    output logic [NSEL-1:0] o_sel
);

    logic [31:0] w_offset;
    logic [31:0] w_slot;

    assign w_offset = i_haddr - REGION_BASE;
    assign w_slot   = w_offset >> REGION_LOG2;
    assign o_hit    = (i_haddr >= REGION_BASE) && (w_slot < 32'(NSEL));

    always_comb begin
        o_sel = '0;
        for (int i = 0; i < NSEL; i++) begin
            if (o_hit && (w_slot == 32'(i))) begin
                o_sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB responder of the AHB-to-APB bridge: one transfer at a time handed to the APB controller via valid/ready.
// Optional REQ-state watchdog enabled by defining AHB_SLV_TIMEOUT_EN.
module ahb_slave_if
    import ahb_slv_pkg::*;
#(
    parameter logic [31:0] REGION_BASE = REGION_BASE_DEF,
    parameter int          REGION_LOG2 = REGION_LOG2_DEF,
    parameter int          NSEL        = 3,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic            i_hclk,
    input  logic            i_hreset,
    input  logic            i_hwrite,
    input  logic            i_hreadyin,
    input  logic [1:0]      i_htrans,
    input  logic [31:0]     i_haddr,
    input  logic [31:0]     i_hwdata,
    output logic [31:0]     o_hrdata,
    output logic [1:0]      o_hresp,
    output logic            o_hreadyout,
    output logic            o_req_valid,
    output logic            o_req_write,
    output logic [31:0]     o_req_addr,
    output logic [31:0]     o_req_wdata,
    output logic [NSEL-1:0] o_req_sel,
    input  logic            i_req_ready,
    input  logic [31:0]     i_rsp_rdata,
    input  logic            i_rsp_err
);

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;
    logic              w_hit;
    logic [NSEL-1:0]   w_sel;
    logic              w_timeout;
    logic [31:0]       r_hrdata;
    logic              r_req_write;
    logic [31:0]       r_req_addr;
    logic [31:0]       r_req_wdata;
    logic [NSEL-1:0]   r_req_sel;

    ahb_addr_decode #(
        .REGION_BASE (REGION_BASE),
        .REGION_LOG2 (REGION_LOG2),
        .NSEL        (NSEL)
    ) u_decode (
        .i_haddr (i_haddr),
        .o_hit   (w_hit),
        .o_sel   (w_sel)
    );

    assign w_accept = i_hreadyin && is_active_trans(i_htrans);

`ifdef AHB_SLV_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);

    logic [TCW-1:0] r_tmo_cnt;

    // Held at zero outside REQ so every REQ entry starts a fresh count.
    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            r_tmo_cnt <= '0;
        end else if (r_state != ST_REQ) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TCW'(1);
        end
    end

    assign w_timeout = (r_state == ST_REQ) && (r_tmo_cnt == TCW'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_hit)        w_state_next = ST_ERR1;
                    else if (i_hwrite) w_state_next = ST_WDATA;
                    else               w_state_next = ST_REQ;
                end
            end
            ST_WDATA: w_state_next = ST_REQ;
            ST_REQ: begin
                if (i_req_ready)    w_state_next = i_rsp_err ? ST_ERR1 : ST_IDLE;
                else if (w_timeout) w_state_next = ST_ERR1;
            end
            ST_ERR1: w_state_next = ST_ERR2;
            ST_ERR2: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Request payload is captured once per transfer and stays stable for the whole REQ phase.
    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            r_state     <= ST_IDLE;
            r_hrdata    <= '0;
            r_req_write <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_sel   <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == ST_IDLE) && w_accept) begin
                r_req_addr  <= i_haddr;
                r_req_write <= i_hwrite;
                r_req_sel   <= w_sel;
            end
            if (r_state == ST_WDATA) begin
                r_req_wdata <= i_hwdata;
            end
            if ((r_state == ST_REQ) && i_req_ready && !i_rsp_err && !r_req_write) begin
                r_hrdata <= i_rsp_rdata;
            end
        end
    end

    assign o_hreadyout = (r_state == ST_IDLE) || (r_state == ST_ERR2);
    assign o_hresp     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign o_req_valid = (r_state == ST_REQ);
    assign o_hrdata    = r_hrdata;
    assign o_req_write = r_req_write;
    assign o_req_addr  = r_req_addr;
    assign o_req_wdata = r_req_wdata;
    assign o_req_sel   = r_req_sel;

endmodule
